load_store_unit: RTL

Sequences data-memory accesses for the core. It accepts one load or store request per transaction from the execute stage over a valid/ready handshake and checks alignment and `funct3`. It then drives the byte-addressable data memory for exactly one cycle and returns a registered, sign- or zero-extended result over a second valid/ready handshake. It sits directly upstream of the data memory: its `mem_*` ports connect 1:1 to the memory's address, write-data, write-enable and read-data ports.

---
 rtl/load_store_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer: one request in, one memory cycle, one registered response.
// Checks width/alignment up front so illegal requests never reach memory.
module load_store_unit #(
    parameter int RegBits = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [2:0]         req_funct3_i,
    input  logic [RegBits-1:0] req_addr_i,
    input  logic [RegBits-1:0] req_wdata_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [RegBits-1:0] resp_rdata_o,
    output logic               resp_err_o,
    output logic [RegBits-1:0] mem_a_o,
    output logic [RegBits-1:0] mem_wd_o,
    output logic [1:0]         mem_we_o,
    input  logic [RegBits-1:0] mem_rd_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RegBits-1:0] addr_q, wdata_q, rdata_q, rdata_ext;
    logic [2:0]         funct3_q;
    logic               we_q, err_q;
    logic               accept, f3_ok, misaligned, req_bad;

    assign accept = req_valid_i && (state_q == IDLE);

    always_comb begin
        f3_ok = 1'b0;
        if (req_we_i)
            f3_ok = req_funct3_i inside {3'd0, 3'd1, 3'd2};
        else
            f3_ok = req_funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
                  || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        req_bad = !f3_ok || misaligned;
    end

    always_comb begin
        rdata_ext = mem_rd_i;
        unique case (funct3_q)
            3'd0:    rdata_ext = {{(RegBits-8){mem_rd_i[7]}}, mem_rd_i[7:0]};
            3'd1:    rdata_ext = {{(RegBits-16){mem_rd_i[15]}}, mem_rd_i[15:0]};
            3'd4:    rdata_ext = {{(RegBits-8){1'b0}}, mem_rd_i[7:0]};
            3'd5:    rdata_ext = {{(RegBits-16){1'b0}}, mem_rd_i[15:0]};
            default: rdata_ext = mem_rd_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = req_bad ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == RESP);
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
        mem_a_o      = addr_q;
        mem_wd_o     = wdata_q;
        // Write enable is purely state-decoded so reset kills it instantly.
        mem_we_o     = 2'b00;
        if (state_q == ACCESS && we_q)
            mem_we_o = funct3_q[1:0] + 2'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            funct3_q <= req_funct3_i;
            we_q     <= req_we_i;
            rdata_q  <= '0;
            err_q    <= req_bad;
        end else if (state_q == ACCESS) begin
            rdata_q  <= we_q ? '0 : rdata_ext;
            err_q    <= 1'b0;
        end
    end

endmodule
